muldiv_unit: RTL and testbench

- Iterative multiply/divide unit driven by the two register-file read outputs (rs, rt); executes MULT, MULTU, DIV, DIVU and holds the architectural HI/LO registers.
- Sits directly downstream of the register file read ports.
- HI/LO feed the writeback mux for MFHI/MFLO.
- busy stalls the PC/fetch while an operation is in flight.

---
 rtl/muldiv_unit.sv | 94 +++++++++
 tb/tb_muldiv_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine holding the HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_start,
    input  logic [1:0]       ctrl_op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             ctrl_mthi,
    input  logic             ctrl_mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic is_div, neg_q, neg_r, sa, sb;
    logic [WIDTH-1:0] a_mag, b_mag, mag_a, mag_b, div_hi, q_fix, r_fix;
    logic [2*WIDTH-1:0] acc, prod_fix;
    logic [WIDTH:0] mul_sum, r_shift, diff;
    // operand signs and magnitudes; unsigned ops take operands as-is
    assign sa = ~ctrl_op[0] & rs_data[WIDTH-1];
    assign sb = ~ctrl_op[0] & rt_data[WIDTH-1];
    assign mag_a = sa ? -rs_data : rs_data;
    assign mag_b = sb ? -rt_data : rt_data;
    // one shift-add / restoring-subtract step plus the final sign correction
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? a_mag : {WIDTH{1'b0}}};
        r_shift = acc[2*WIDTH-1:WIDTH-1];
        diff = r_shift - {1'b0, b_mag};
        div_hi = diff[WIDTH] ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];
        prod_fix = neg_q ? -acc : acc;
        q_fix = (b_mag == '0) ? '1 : neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // next-state: start in IDLE, WIDTH iterations in RUN, one fix-up cycle
    always_comb begin
        state_nx = (state == IDLE && ctrl_start) ? RUN :
                   (state == RUN && cnt == LAST) ? FIX :
                   (state == FIX) ? IDLE : state;
    end
    // outputs decoded from state
    always_comb begin
        busy = state != IDLE;
    end
    // datapath: operand latch, iteration, HI/LO writes and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            is_div <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            a_mag <= '0;
            b_mag <= '0;
            acc <= '0;
            hi <= '0;
            lo <= '0;
            done <= 1'b0;
        end else begin
            done <= state == FIX;
            if (state == IDLE) begin
                if (ctrl_start) begin
                    cnt <= '0;
                    is_div <= ctrl_op[1];
                    neg_q <= sa ^ sb;
                    neg_r <= sa;
                    a_mag <= mag_a;
                    b_mag <= mag_b;
                    acc <= {{WIDTH{1'b0}}, ctrl_op[1] ? mag_a : mag_b};
                end else begin
                    if (ctrl_mthi) hi <= rs_data;
                    if (ctrl_mtlo) lo <= rs_data;
                end
            end else if (state == RUN) begin
                cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
                acc <= is_div ? {div_hi, acc[WIDTH-2:0], ~diff[WIDTH]} : {mul_sum, acc[WIDTH-1:1]};
            end else begin
                hi <= is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
                lo <= is_div ? q_fix : prod_fix[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors against an arithmetic reference model of muldiv_unit
module tb_muldiv_unit;
    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [1:0] op = 2'd0;
    logic [31:0] rs = '0, rt = '0;
    logic busy, done;
    logic [31:0] hi, lo;
    int checks = 0, errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .ctrl_start(start), .ctrl_op(op),
        .rs_data(rs), .rt_data(rt), .ctrl_mthi(mthi), .ctrl_mtlo(mtlo),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference result {hi,lo} straight from the arithmetic definition of each op
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint la, lb, p;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        case (o)
            2'd0: begin p = la * lb; return 64'(p); end
            2'd1: return {32'd0, a} * {32'd0, b};
            2'd2: return (b == 0) ? {a, 32'hFFFFFFFF} : {32'(la % lb), 32'(la / lb)};
            default: return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
        endcase
    endfunction

    // cycle model: a start costs 33 busy cycles, result lands with a one-cycle done
    int left;
    logic m_done;
    logic [31:0] m_hi, m_lo;
    logic [63:0] pend;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            left <= 0;
            m_done <= 1'b0;
            m_hi <= '0;
            m_lo <= '0;
        end else begin
            m_done <= (left == 1);
            if (left > 0) begin
                left <= left - 1;
                if (left == 1) {m_hi, m_lo} <= pend;
            end else if (start) begin
                left <= 33;
                pend <= model(op, rs, rt);
            end else begin
                if (mthi) m_hi <= rs;
                if (mtlo) m_lo <= rs;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 64'(busy), 64'(left != 0));
            chk("done", 64'(done), 64'(m_done));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
        end
    end

    // issue an op at a negedge in IDLE; optionally poke start/MTHI mid-flight
    task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input bit poke);
        int n;
        start = 1'b1; op = o; rs = a; rt = b;
        @(negedge clk);
        start = 1'b0; rs = ~a; rt = ~b;
        n = 0;
        while (busy && n < 50) begin
            n++;
            if (poke && n == 5) begin start = 1'b1; op = ~o; mthi = 1'b1; rs = 32'hDEADBEEF; end
            if (poke && n == 6) begin start = 1'b0; mthi = 1'b0; end
            @(negedge clk);
        end
        chk({nm, " latency"}, 64'(n), 64'd33);
        chk({nm, " done"}, 64'(done), 64'd1);
        chk({nm, " hi"}, 64'(hi), 64'(eh));
        chk({nm, " lo"}, 64'(lo), 64'(el));
        @(negedge clk);
        chk({nm, " done drop"}, 64'(done), 64'd0);
    endtask

    initial begin
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("model multu", model(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
        chk("model div", model(2'd2, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
        chk("model div ovf", model(2'd2, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
        do_op("multu max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        do_op("mult -3x7", 2'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1);
        do_op("mult minsq", 2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);
        do_op("div -7/2", 2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        do_op("div 7/-2", 2'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b1);
        do_op("divu 100/7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        do_op("div ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
        do_op("divu 5/0", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b0);
        do_op("div -5/0", 2'd2, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0);
        mtlo = 1'b1; rs = 32'h1234;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mtlo lo", 64'(lo), 64'h1234);
        chk("mtlo done", 64'(done), 64'd0);
        mthi = 1'b1; mtlo = 1'b1; rs = 32'hCAFE;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("mthilo", {hi, lo}, {32'hCAFE, 32'hCAFE});
        mthi = 1'b1; mtlo = 1'b1;
        do_op("start beats mt", 2'd1, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
        mthi = 1'b0; mtlo = 1'b0;
        do_op("multu pre", 2'd1, 32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E, 32'h242D2080, 1'b0);
        start = 1'b1; op = 2'd1; rs = 32'hFFFF0000; rt = 32'h0000FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst mid busy", 64'(busy), 64'd0);
        chk("rst mid done", 64'(done), 64'd0);
        chk("rst mid hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op("after rst", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
